// File: rtl/rand_gap_arbiter.sv
// rand_gap_arbiter: N:1 valid/ready arbiter with a pseudo-random winner and a
// random idle gap of [cfg_min_i, cfg_max_i] cycles after every downstream transfer.
// Optional transfer/gap statistics counters are enabled by RAND_GAP_ARB_STATS_EN;
// without it stat_xfer_o and stat_gap_o are tied to zero.
module rand_gap_arbiter #(
    parameter int unsigned NumReq    = 4,
    parameter int unsigned DataWidth = 32,
    parameter logic [31:0] LfsrSeed  = 32'hACE1_2468,
    parameter int unsigned IdxWidth  = (NumReq > 1) ? $clog2(NumReq) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic [7:0]                  cfg_min_i,
    input  logic [7:0]                  cfg_max_i,
    input  logic [NumReq-1:0]           req_valid_i,
    output logic [NumReq-1:0]           req_ready_o,
    input  logic [NumReq*DataWidth-1:0] req_data_i,
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic [DataWidth-1:0]        out_data_o,
    output logic [IdxWidth-1:0]         out_idx_o,
    output logic [31:0]                 stat_xfer_o,
    output logic [31:0]                 stat_gap_o
);

    localparam logic [31:0]       LFSR_MASK = 32'h8020_0003;
    localparam logic [31:0]       LFSR_INIT = (LfsrSeed == 32'd0) ? 32'd1 : LfsrSeed;
    localparam int unsigned       SUM_W     = IdxWidth + 1;
    localparam logic [SUM_W-1:0]  NUM_REQ_S = SUM_W'(NumReq);

    typedef enum logic [1:0] {
        ST_ARB  = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t                state;
    logic [7:0]            gap_cnt;
    logic [31:0]           lfsr;
    logic [31:0]           lfsr_next;
    logic [IdxWidth-1:0]   start_idx;
    logic [SUM_W-1:0]      cand_sum;
    logic [IdxWidth-1:0]   cand_idx;
    logic [IdxWidth-1:0]   win_idx;
    logic [DataWidth-1:0]  win_data;
    logic                  win_any;
    logic [7:0]            gap_span;
    logic [7:0]            gap_ofs;
    logic [7:0]            gap_draw;
    logic                  out_hs;

    assign out_hs = out_valid_o && out_ready_i;

    // Galois LFSR step (right shift, feedback from bit 0)
    always_comb begin
        lfsr_next = {1'b0, lfsr[31:1]} ^ (lfsr[0] ? LFSR_MASK : 32'd0);
    end

    // Random start index and gap length drawn from the current LFSR value
    always_comb begin
        start_idx = IdxWidth'(lfsr[31:16] % 16'(NumReq));
        gap_span  = (cfg_max_i > cfg_min_i) ? (cfg_max_i - cfg_min_i) : 8'd0;
        gap_ofs   = 8'(lfsr[15:0] % (16'(gap_span) + 16'd1));
        gap_draw  = cfg_min_i + gap_ofs;
    end

    // Rotating first-valid search from start_idx; grant is combinational in ARB
    always_comb begin
        win_any     = 1'b0;
        win_idx     = '0;
        win_data    = '0;
        cand_sum    = '0;
        cand_idx    = '0;
        req_ready_o = '0;
        // Walk from the farthest candidate back so the nearest valid one wins
        for (int i = int'(NumReq) - 1; i >= 0; i--) begin
            cand_sum = SUM_W'(start_idx) + SUM_W'(i);
            if (cand_sum >= NUM_REQ_S) begin
                cand_sum = cand_sum - NUM_REQ_S;
            end
            cand_idx = IdxWidth'(cand_sum);
            if (req_valid_i[cand_idx]) begin
                win_any  = 1'b1;
                win_idx  = cand_idx;
                win_data = req_data_i[cand_idx*DataWidth +: DataWidth];
            end
        end
        // No grant during reset so a requester never loses a beat to it
        if (state == ST_ARB && !rst_i && win_any) begin
            req_ready_o[win_idx] = 1'b1;
        end
    end

    // Arbitration FSM, gap counter, LFSR and registered downstream outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= ST_ARB;
            gap_cnt     <= 8'd0;
            lfsr        <= LFSR_INIT;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_idx_o   <= '0;
        end else begin
            lfsr <= lfsr_next;
            case (state)
                ST_ARB: begin
                    if (win_any) begin
                        out_data_o  <= win_data;
                        out_idx_o   <= win_idx;
                        out_valid_o <= 1'b1;
                        state       <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (out_hs) begin
                        out_valid_o <= 1'b0;
                        if (gap_draw == 8'd0) begin
                            state <= ST_ARB;
                        end else begin
                            gap_cnt <= gap_draw - 8'd1;
                            state   <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (gap_cnt == 8'd0) begin
                        state <= ST_ARB;
                    end else begin
                        gap_cnt <= gap_cnt - 8'd1;
                    end
                end
                default: begin
                    state       <= ST_ARB;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAND_GAP_ARB_STATS_EN
    logic [31:0] xfer_q;
    logic [31:0] gapc_q;

    // Free-running statistics: downstream transfers and cycles spent idling
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            xfer_q <= 32'd0;
            gapc_q <= 32'd0;
        end else begin
            if (out_hs) begin
                xfer_q <= xfer_q + 32'd1;
            end
            if (state == ST_WAIT) begin
                gapc_q <= gapc_q + 32'd1;
            end
        end
    end

    assign stat_xfer_o = xfer_q;
    assign stat_gap_o  = gapc_q;
`else
    assign stat_xfer_o = 32'd0;
    assign stat_gap_o  = 32'd0;
`endif

endmodule

// File: tb/tb_rand_gap_arbiter.sv
// Scoreboard bench for rand_gap_arbiter: a timestamp-based reference model
// predicts grants and beats; a separate monitor pops and compares each beat.
module tb_rand_gap_arbiter;

    localparam int unsigned N    = 4;
    localparam int unsigned DW   = 32;
    localparam int unsigned IW   = 2;
    localparam logic [31:0] SEED = 32'hACE1_2468;

    logic            clk;
    logic            rst;
    logic [7:0]      cfg_min;
    logic [7:0]      cfg_max;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_data;
    logic            out_valid;
    logic            out_ready;
    logic [DW-1:0]   out_data;
    logic [IW-1:0]   out_idx;
    logic [31:0]     stat_xfer;
    logic [31:0]     stat_gap;

    rand_gap_arbiter #(.NumReq(N), .DataWidth(DW), .LfsrSeed(SEED)) dut (
        .clk_i(clk), .rst_i(rst), .cfg_min_i(cfg_min), .cfg_max_i(cfg_max),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_idx_o(out_idx), .stat_xfer_o(stat_xfer), .stat_gap_o(stat_gap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Stimulus knobs applied at each falling edge
    logic         d_rst   = 1'b1;
    logic [7:0]   d_min   = 8'd0;
    logic [7:0]   d_max   = 8'd0;
    logic [N-1:0] d_vmask = '0;
    bit           d_vrand = 1'b0;
    int           d_pct   = 100;
    int           seq [N];

    // Reference model: next cycle the arbiter is free, and whether a beat is held
    logic [31:0]        m_lfsr = SEED;
    int                 m_cyc  = 0;
    int                 m_free = 0;
    bit                 m_hold = 1'b0;
    logic [IW+DW-1:0]   exp_q [$];

    // Monitor state
    int           hs_count  = 0;
    int           idx_cnt [N];
    int           idle_run  = 0;
    bit           have_prev = 1'b0;
    int           gaps_q [$];
    bit           prev_valid = 1'b0;
    bit           prev_hs    = 1'b0;
    logic [DW-1:0] prev_data;
    logic [IW-1:0] prev_idx;

    function automatic logic [31:0] lfsr_step(input logic [31:0] x);
        return x[0] ? ((x >> 1) ^ 32'h8020_0003) : (x >> 1);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle prediction of grant, out_valid and the gap drawn at each transfer
    task automatic model_step();
        logic [N-1:0] exp_ready;
        int s, w, span, g;
        if (rst) begin
            chk("ready_in_reset", 64'(req_ready), 64'(0));
            m_lfsr = SEED;
            m_hold = 1'b0;
            m_free = m_cyc + 1;
            exp_q.delete();
            m_cyc++;
            return;
        end
        exp_ready = '0;
        chk("ready_onehot0", 64'($onehot0(req_ready)), 64'(1));
        chk("ready_wo_valid", 64'(req_ready & ~req_valid), 64'(0));
        if (m_hold) begin
            chk("out_valid_send", 64'(out_valid), 64'(1));
            if (out_ready) begin
                span   = (int'(cfg_max) > int'(cfg_min)) ? int'(cfg_max) - int'(cfg_min) : 0;
                g      = int'(cfg_min) + (int'(m_lfsr[15:0]) % (span + 1));
                m_free = m_cyc + 1 + g;
                m_hold = 1'b0;
            end
        end else begin
            chk("out_valid_idle", 64'(out_valid), 64'(0));
            if (m_cyc >= m_free && req_valid != '0) begin
                s = int'(m_lfsr[31:16]) % int'(N);
                w = -1;
                for (int i = 0; i < int'(N); i++) begin
                    int k;
                    k = (s + i) % int'(N);
                    if (w < 0 && req_valid[k]) w = k;
                end
                exp_ready[w] = 1'b1;
                exp_q.push_back({IW'(w), 8'(w), 24'(seq[w])});
                seq[w]++;
                m_hold = 1'b1;
            end
        end
        chk("req_ready", 64'(req_ready), 64'(exp_ready));
        m_lfsr = lfsr_step(m_lfsr);
        m_cyc++;
    endtask

    // One clock: drive at falling edge, predict/check, leave room for the monitor
    task automatic cycle();
        @(negedge clk);
        rst     = d_rst;
        cfg_min = d_min;
        cfg_max = d_max;
        for (int k = 0; k < int'(N); k++) req_data[k*DW +: DW] = {8'(k), 24'(seq[k])};
        req_valid = d_vrand ? (N'($urandom) & d_vmask) : d_vmask;
        out_ready = ($urandom_range(0, 99) < d_pct);
        #2;
        model_step();
        #2;
    endtask

    task automatic run_beats(input string name, input int n, input int budget);
        int target, c;
        target = hs_count + n;
        c = 0;
        while (hs_count < target && c < budget) begin
            cycle();
            c++;
        end
        chk({name, "_done"}, 64'(hs_count >= target), 64'(1));
    endtask

    task automatic gap_start();
        gaps_q.delete();
        have_prev = 1'b0;
    endtask

    task automatic check_gaps(input string name, input int lo, input int hi, input bit need_all);
        int bad;
        int seen [256];
        bad = 0;
        for (int v = 0; v < 256; v++) seen[v] = 0;
        foreach (gaps_q[j]) begin
            if (gaps_q[j] < lo || gaps_q[j] > hi) bad++;
            else seen[gaps_q[j]]++;
        end
        chk({name, "_range"}, 64'(bad), 64'(0));
        chk({name, "_count"}, 64'(gaps_q.size() > 0), 64'(1));
        if (need_all) begin
            for (int v = lo; v <= hi; v++) chk({name, "_seen"}, 64'(seen[v] > 0), 64'(1));
        end
    endtask

    task automatic check_reset_state();
        @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        chk("rst_out_idx", 64'(out_idx), 64'(0));
        chk("rst_req_ready", 64'(req_ready), 64'(0));
        chk("rst_stat_xfer", 64'(stat_xfer), 64'(0));
        chk("rst_stat_gap", 64'(stat_gap), 64'(0));
    endtask

    // Monitor: pops the expected beat on every downstream handshake
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst) begin
                prev_valid = 1'b0;
                idle_run   = 0;
                have_prev  = 1'b0;
            end else begin
                if (prev_valid && !prev_hs && out_valid) begin
                    chk("stall_data", 64'(out_data), 64'(prev_data));
                    chk("stall_idx", 64'(out_idx), 64'(prev_idx));
                end
                if (out_valid && out_ready) begin
                    hs_count++;
                    idx_cnt[out_idx]++;
                    if (exp_q.size() == 0) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL beat: got idx %0d data 0x%0h, expected no beat", out_idx, out_data);
                    end else begin
                        chk("beat", 64'({out_idx, out_data}), 64'(exp_q.pop_front()));
                    end
                    if (have_prev) gaps_q.push_back(idle_run - 1);
                    have_prev = 1'b1;
                    idle_run  = 0;
                end else if (!out_valid) begin
                    idle_run++;
                end
                prev_valid = out_valid;
                prev_hs    = out_valid && out_ready;
                prev_data  = out_data;
                prev_idx   = out_idx;
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int k = 0; k < int'(N); k++) begin
            seq[k] = 0;
            idx_cnt[k] = 0;
        end
        rst = 1'b1; cfg_min = 8'd0; cfg_max = 8'd0;
        req_valid = '0; req_data = '0; out_ready = 1'b0;

        // Reset state
        d_rst = 1'b1;
        cycle();
        cycle();
        check_reset_state();
        d_rst = 1'b0;

        // Minimum gap: 100 beats in exactly 200 cycles from requester 0
        d_min = 8'd0; d_max = 8'd0; d_vmask = 4'b0001; d_pct = 100;
        base = hs_count;
        for (int c = 0; c < 200; c++) cycle();
        chk("min_gap_beats", 64'(hs_count - base), 64'(100));
        chk("min_gap_idx1", 64'(idx_cnt[1] + idx_cnt[2] + idx_cnt[3]), 64'(0));

        // Fixed gap of 3
        d_min = 8'd3; d_max = 8'd3;
        gap_start();
        run_beats("fixed3", 40, 400);
        check_gaps("fixed3", 3, 3, 1'b0);

        // Random gaps in [2,9], every value seen
        d_min = 8'd2; d_max = 8'd9;
        gap_start();
        run_beats("rand29", 1000, 12000);
        check_gaps("rand29", 2, 9, 1'b1);

        // Inverted config: gap is exactly cfg_min
        d_min = 8'd9; d_max = 8'd2;
        gap_start();
        run_beats("inv92", 50, 700);
        check_gaps("inv92", 9, 9, 1'b0);

        // Fairness with every requester always valid
        d_min = 8'd0; d_max = 8'd0; d_vmask = 4'b1111;
        run_beats("settle", 2, 50);
        for (int k = 0; k < int'(N); k++) idx_cnt[k] = 0;
        run_beats("fair", 4000, 8200);
        for (int k = 0; k < int'(N); k++)
            chk("fair_share", 64'(idx_cnt[k] >= 850 && idx_cnt[k] <= 1150), 64'(1));

        // Random valids, random backpressure, config changes
        d_vrand = 1'b1; d_vmask = 4'b1111; d_pct = 70;
        for (int c = 0; c < 3000; c++) begin
            if (c % 100 == 0) begin
                d_min = 8'($urandom_range(0, 3));
                d_max = 8'($urandom_range(0, 6));
            end
            cycle();
        end

        // Backpressure for 20 cycles in SEND, then reset mid-SEND
        d_vrand = 1'b0; d_vmask = 4'b0001; d_pct = 0;
        for (int c = 0; c < 300 && !out_valid; c++) cycle();
        chk("bp_in_send", 64'(out_valid), 64'(1));
        for (int c = 0; c < 20; c++) cycle();
        chk("bp_still_valid", 64'(out_valid), 64'(1));
        d_rst = 1'b1; d_vmask = '0;
        cycle();
        check_reset_state();
        d_rst = 1'b0;

        // Statistics after ten transfers with a gap of 5
        d_min = 8'd5; d_max = 8'd5; d_vmask = 4'b0001; d_pct = 100;
        run_beats("stats", 10, 200);
        @(posedge clk);
        #1;
`ifdef RAND_GAP_ARB_STATS_EN
        chk("stat_xfer", 64'(stat_xfer), 64'(10));
        chk("stat_gap", 64'(stat_gap), 64'(45));
`else
        chk("stat_xfer_off", 64'(stat_xfer), 64'(0));
        chk("stat_gap_off", 64'(stat_gap), 64'(0));
`endif

        // Drain: no beat left unaccounted
        d_vmask = '0; d_min = 8'd0; d_max = 8'd0;
        for (int c = 0; c < 40; c++) cycle();
        chk("drain_empty", 64'(exp_q.size()), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rand_gap_arbiter.md
Name: rand_gap_arbiter

Overview:
- Synthesizable N:1 arbiter for constrained-random benches and FPGA stress designs.
- Shares one downstream valid/ready port between NumReq requesters.
- Picks the winner pseudo-randomly; inserts a random idle gap of [cfg_min_i, cfg_max_i] cycles after each transfer.
- Hardware counterpart of the package's random-wait task; sits between traffic generators and the DUT input.

Parameters:
- NumReq, 4, number of requesters (>=1)
- DataWidth, 32, payload width per requester
- LfsrSeed, 32'hACE1_2468, LFSR reset value; a value of 0 is replaced by 32'h1
- IdxWidth, (NumReq>1 ? $clog2(NumReq) : 1), width of out_idx_o (derived, do not override)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  synchronous active-high reset
- cfg_min_i  in  8  minimum gap in cycles
- cfg_max_i  in  8  maximum gap in cycles
- req_valid_i  in  NumReq  per-requester valid
- req_ready_o  out  NumReq  per-requester ready (one-hot or zero)
- req_data_i  in  NumReq*DataWidth  payloads; requester k uses bits [k*DataWidth +: DataWidth]
- out_valid_o  out  1  downstream valid
- out_ready_i  in  1  downstream ready
- out_data_o  out  DataWidth  registered payload
- out_idx_o  out  IdxWidth  index of the requester that supplied out_data_o
- stat_xfer_o  out  32  completed transfers (optional feature)
- stat_gap_o  out  32  gap cycles spent in WAIT (optional feature)

Behaviour:
- Reset (rst_i high at a clock edge): state=ARB, counter=0, lfsr=seed, all outputs 0. A beat in flight is discarded and is not re-offered.
- LFSR: 32-bit Galois, mask 32'h8020_0003. Advances every cycle outside reset.
- Gap draw: span = (cfg_max_i > cfg_min_i) ? cfg_max_i - cfg_min_i : 0; gap = cfg_min_i + (lfsr[15:0] mod (span+1)). Result is 8-bit with no overflow. Config is sampled only at the draw.
- Start index: s = lfsr[31:16] mod NumReq.
- State ARB:
  - No req_valid_i set: stay in ARB; req_ready_o=0.
  - Otherwise the winner is the first set valid searching s, s+1, ... with wrap-around.
  - req_ready_o[winner]=1 combinationally in this cycle; the handshake completes.
  - Data and index are registered; next state is SEND.
  - At most one ready bit is set; ready never asserts without the matching valid.
- State SEND:
  - out_valid_o=1; out_data_o and out_idx_o stable until the handshake.
  - On out_valid_o && out_ready_i: draw gap. If gap==0 go to ARB, else counter=gap-1 and go to WAIT.
  - No backpressure timeout.
- State WAIT:
  - out_valid_o=0, req_ready_o=0.
  - Counter decrements each cycle; at counter==0 go to ARB.
  - Idle gap is exactly `gap` cycles.
- Latency and throughput:
  - Requester handshake to out_valid_o = 1 cycle.
  - Best case one transfer per 2 cycles (cfg_min_i=cfg_max_i=0).
- Requesters may drop valid while not granted; the arbiter never relies on valid persistence.
- Simultaneous requests: exactly one is served per ARB cycle; the others wait.

Optional Feature:
- Macro: RAND_GAP_ARB_STATS_EN
- Defined:
  - stat_xfer_o increments on each downstream handshake.
  - stat_gap_o increments each cycle spent in WAIT.
  - Both counters wrap at 2^32 and clear on reset.
- Not defined: both ports tied to 0; no counter flops inferred.

Test Plan:
- Min gap: cfg_min=cfg_max=0, requester 0 always valid, out_ready_i=1 -> 100 beats in exactly 200 cycles; out_idx_o=0 throughout; beats in order.
- Fixed gap: cfg_min=cfg_max=3, single requester, out_ready_i=1 -> every pair of downstream handshakes separated by exactly 3+1 cycles with out_valid_o=0 gaps.
- Random gaps: cfg_min=2, cfg_max=9, 1000 beats -> every gap in [2,9]; each value 2..9 observed at least once. Also cfg_min=9, cfg_max=2 -> every gap exactly 9.
- Fairness: all 4 requesters always valid, 4000 beats -> each index gets 1000±150 grants; req_ready_o always one-hot or zero; never ready without valid; no payload lost or duplicated (scoreboard).
- Backpressure and mid-operation reset:
  - out_ready_i low for 20 cycles in SEND -> out_valid_o, out_data_o and out_idx_o stable; no further req_ready_o.
  - Assert rst_i for 1 cycle mid-SEND -> next cycle all outputs 0 and state ARB.
  - With RAND_GAP_ARB_STATS_EN: counters read 0 after reset.
- Stats (with RAND_GAP_ARB_STATS_EN): cfg_min=cfg_max=5, 10 beats -> stat_xfer_o=10, stat_gap_o=45 when checked right after the 10th handshake.
